multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Multi-cycle control unit: a registered state machine that sequences each instruction through IF/ID/EXE/MEM/WB and drives all datapath enables and selects. It sits directly upstream of the register file and supplies that block's `RegWrite`, `MemtoReg` and write-register selection. It also controls the PC, instruction register, ALU and data memory. Opcode, `zero` and `sign` come from the instruction register and ALU.

## Interface
- No parameters; state encoding fixed: IF=000, ID=001, EXE_MEM=010, MEM=011, WB_L=100, EXE_BR=101, EXE_R=110, WB_R=111.
- `CLK  in  1  system clock, rising edge`
- `Reset  in  1  asynchronous, active-low reset`
- `opcode  in  6  IR[31:26], stable from ID onward`
- `zero  in  1  ALU result == 0`
- `sign  in  1  ALU result[31]`
- `state  out  3  current state`
- `PCWre  out  1  PC load enable`
- `IRWre  out  1  instruction register load`
- `RegWrite  out  1  register file write enable`
- `MemtoReg  out  1  1 = write-back from data memory, 0 = from ALU`
- `RegDst  out  2  write register: 00 = $31, 01 = rt, 10 = rd`
- `WrRegDSrc  out  1  0 = PC+4 (jal), 1 = ALU/memory data`
- `ALUSrcA  out  1  1 = shamt (sll)`
- `ALUSrcB  out  1  1 = extended immediate`
- `ExtSel  out  1  0 = zero-extend, 1 = sign-extend`
- `ALUOp  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 110 signed slt`
- `PCSrc  out  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump target`
- `mRD, mWR  out  1 each  data memory read/write strobes`

## Operation
- Opcodes:
  - add 000000, sub 000001, addiu 000010
  - and 010001, andi 010000, or 010011, ori 010010
  - sll 011000, slt 100111, slti 100110
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010, halt 111111
- Transitions:
  - IF→ID always.
  - ID→IF for j/jr/jal and any undefined opcode (undefined = nop).
  - ID→ID for halt.
  - ID→EXE_BR for branches, then EXE_BR→IF.
  - ID→EXE_MEM for sw/lw, then EXE_MEM→MEM.
  - MEM→IF for sw; MEM→WB_L for lw, then WB_L→IF.
  - ID→EXE_R for all other opcodes, then EXE_R→WB_R→IF.
- Outputs are a combinational decode of the registered `state` plus `opcode`/`zero`/`sign`; there are no output glitch registers.
- PCWre=1 only in an instruction's final state, so the PC updates on the edge that enters IF:
  - ID for j/jr/jal/undefined
  - EXE_BR
  - MEM for sw
  - WB_R, WB_L
- PCWre is 0 in ID for halt.
- IRWre=1 only in IF.
- RegWrite=1:
  - in WB_R and WB_L;
  - in ID for jal, with RegDst=00 and WrRegDSrc=0.
- RegWrite=0 in every other state.
- MemtoReg=1 only in WB_L.
- RegDst=10 for R-type (add/sub/and/or/slt/sll); 01 for immediates and lw.
- mWR=1 only in MEM for sw; mRD=1 only in MEM for lw.
- ALUSrcB=1 for addiu/andi/ori/slti/sw/lw. ALUSrcA=1 for sll.
- ExtSel=0 for andi/ori; 1 otherwise.
- ALUOp:
  - sub for sub/beq/bne/bltz
  - slt for slt/slti
  - add for add/addiu/sw/lw
- PCSrc:
  - 01 in EXE_BR when taken: beq with zero=1, bne with zero=0, bltz with sign=1; else 00.
  - 11 for j/jal, 10 for jr, 00 otherwise.
- Unused outputs (selects not listed above) are driven 0.

## Timing
- Reset low, asynchronous: state=IF immediately.
- While Reset is low, PCWre, IRWre, RegWrite, mRD and mWR are forced 0 regardless of state; all other outputs are 0.
- First IF is after Reset deasserts; IRWre=1 from that point.
- Reset mid-instruction (e.g. in WB_R or MEM): write enables drop in the same cycle and no partial write occurs after Reset falls.
- Cycles per instruction:
  - j/jr/jal: 2
  - beq/bne/bltz: 3
  - R-type/immediate: 4
  - sw: 4
  - lw: 5
- `zero`/`sign` are sampled combinationally during EXE_BR; they must be valid before the edge leaving EXE_BR.
- Halt: remains in ID indefinitely with all enables 0; only Reset exits.
- `opcode` changes while not in IF have no effect on the state sequence except through the decode in the current state.

## Test plan
- Reset low mid-EXE_R → state=000 within the same cycle; PCWre/RegWrite/mWR=0. Release → IF with IRWre=1.
- opcode=000000 (add) → states 000,001,110,111,000. Only WB_R has RegWrite=1, RegDst=10, MemtoReg=0, PCWre=1. ALUOp=000 in EXE_R.
- opcode=110001 (lw) → 000,001,010,011,100,000. mRD=1 only in MEM. WB_L has RegWrite=1, MemtoReg=1, RegDst=01.
- opcode=110000 (sw) → 000,001,010,011,000. mWR=1 and PCWre=1 in MEM; RegWrite never 1.
- beq with zero=1 → PCSrc=01 in EXE_BR. With zero=0 → PCSrc=00. bltz with sign=1 → PCSrc=01. Each takes 3 cycles.
- jal → ID has RegWrite=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1; next state IF.
- halt (111111) → state stays 001 for 20 cycles with PCWre=0 and RegWrite=0.

Source files
------------

// File: rtl/multi_cycle_control_if.sv
// ============================================================================
//  Module      : multi_cycle_control_if
//  Description : Control bus between the multi-cycle control unit and its
//                datapath. It carries the opcode and ALU flags in, and the
//                state plus every datapath enable and select out.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multi_cycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       sign;
    logic [2:0] state;
    logic       PCWre;
    logic       IRWre;
    logic       RegWrite;
    logic       MemtoReg;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       ExtSel;
    logic [2:0] ALUOp;
    logic [1:0] PCSrc;
    logic       mRD;
    logic       mWR;

    // Control unit side: consumes opcode/flags, drives the datapath controls.
    modport master (
        input  opcode, zero, sign,
        output state, PCWre, IRWre, RegWrite, MemtoReg, RegDst, WrRegDSrc,
               ALUSrcA, ALUSrcB, ExtSel, ALUOp, PCSrc, mRD, mWR
    );

    // Datapath side: supplies opcode/flags, obeys the controls.
    modport slave (
        output opcode, zero, sign,
        input  state, PCWre, IRWre, RegWrite, MemtoReg, RegDst, WrRegDSrc,
               ALUSrcA, ALUSrcB, ExtSel, ALUOp, PCSrc, mRD, mWR
    );
endinterface

`default_nettype wire

// File: rtl/multi_cycle_control.sv
// ============================================================================
//  Module      : multi_cycle_control
//  Description : Multi-cycle control FSM. Sequences each instruction through
//                IF/ID/EXE/MEM/WB and decodes all datapath controls from the
//                registered state plus opcode/zero/sign.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_cycle_control (
    input  wire logic              CLK,
    input  wire logic              Reset,
    multi_cycle_control_if.master  bus
);

    typedef enum logic [2:0] {
        S_IF      = 3'b000,
        S_ID      = 3'b001,
        S_EXE_MEM = 3'b010,
        S_MEM     = 3'b011,
        S_WB_L    = 3'b100,
        S_EXE_BR  = 3'b101,
        S_EXE_R   = 3'b110,
        S_WB_R    = 3'b111
    } state_t;

    localparam logic [5:0] c_OP_ADD   = 6'b000000;
    localparam logic [5:0] c_OP_SUB   = 6'b000001;
    localparam logic [5:0] c_OP_ADDIU = 6'b000010;
    localparam logic [5:0] c_OP_ANDI  = 6'b010000;
    localparam logic [5:0] c_OP_AND   = 6'b010001;
    localparam logic [5:0] c_OP_ORI   = 6'b010010;
    localparam logic [5:0] c_OP_OR    = 6'b010011;
    localparam logic [5:0] c_OP_SLL   = 6'b011000;
    localparam logic [5:0] c_OP_SLTI  = 6'b100110;
    localparam logic [5:0] c_OP_SLT   = 6'b100111;
    localparam logic [5:0] c_OP_SW    = 6'b110000;
    localparam logic [5:0] c_OP_LW    = 6'b110001;
    localparam logic [5:0] c_OP_BEQ   = 6'b110100;
    localparam logic [5:0] c_OP_BNE   = 6'b110101;
    localparam logic [5:0] c_OP_BLTZ  = 6'b110110;
    localparam logic [5:0] c_OP_J     = 6'b111000;
    localparam logic [5:0] c_OP_JR    = 6'b111001;
    localparam logic [5:0] c_OP_JAL   = 6'b111010;
    localparam logic [5:0] c_OP_HALT  = 6'b111111;

    state_t state_q;
    state_t state_d;

    logic [5:0] w_op;
    logic       w_is_rtype;
    logic       w_is_imm;
    logic       w_is_mem;
    logic       w_is_br;
    logic       w_is_jump;
    logic       w_is_halt;
    logic       w_is_defined;

    assign w_op       = bus.opcode;
    assign w_is_rtype = (w_op == c_OP_ADD) || (w_op == c_OP_SUB) || (w_op == c_OP_AND) ||
                        (w_op == c_OP_OR)  || (w_op == c_OP_SLL) || (w_op == c_OP_SLT);
    assign w_is_imm   = (w_op == c_OP_ADDIU) || (w_op == c_OP_ANDI) ||
                        (w_op == c_OP_ORI)   || (w_op == c_OP_SLTI);
    assign w_is_mem   = (w_op == c_OP_SW) || (w_op == c_OP_LW);
    assign w_is_br    = (w_op == c_OP_BEQ) || (w_op == c_OP_BNE) || (w_op == c_OP_BLTZ);
    assign w_is_jump  = (w_op == c_OP_J) || (w_op == c_OP_JR) || (w_op == c_OP_JAL);
    assign w_is_halt  = (w_op == c_OP_HALT);
    assign w_is_defined = w_is_rtype || w_is_imm || w_is_mem || w_is_br || w_is_jump || w_is_halt;

    // State register; asynchronous reset returns straight to instruction fetch.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    // Next-state selection; undefined opcodes retire in ID like a nop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:      state_d = S_ID;
            S_ID: begin
                if (w_is_halt)                     state_d = S_ID;
                else if (w_is_jump || !w_is_defined) state_d = S_IF;
                else if (w_is_br)                  state_d = S_EXE_BR;
                else if (w_is_mem)                 state_d = S_EXE_MEM;
                else                               state_d = S_EXE_R;
            end
            S_EXE_MEM: state_d = S_MEM;
            S_MEM:     state_d = (w_op == c_OP_LW) ? S_WB_L : S_IF;
            S_WB_L:    state_d = S_IF;
            S_EXE_BR:  state_d = S_IF;
            S_EXE_R:   state_d = S_WB_R;
            S_WB_R:    state_d = S_IF;
            default:   state_d = S_IF;
        endcase
    end

    // Control decode; everything is held at 0 while Reset is low so no write
    // can leak out of an interrupted instruction.
    always_comb begin
        bus.state     = 3'b000;
        bus.PCWre     = 1'b0;
        bus.IRWre     = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.RegDst    = 2'b00;
        bus.WrRegDSrc = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 1'b0;
        bus.ExtSel    = 1'b0;
        bus.ALUOp     = 3'b000;
        bus.PCSrc     = 2'b00;
        bus.mRD       = 1'b0;
        bus.mWR       = 1'b0;
        if (Reset) begin
            bus.state = state_q;
            // Datapath selects follow the opcode once it is in the IR.
            if (state_q != S_IF) begin
                if (w_is_rtype)                      bus.RegDst = 2'b10;
                else if (w_is_imm || w_op == c_OP_LW) bus.RegDst = 2'b01;
                bus.ALUSrcA = (w_op == c_OP_SLL);
                bus.ALUSrcB = w_is_imm || w_is_mem;
                bus.ExtSel  = !((w_op == c_OP_ANDI) || (w_op == c_OP_ORI));
                case (w_op)
                    c_OP_SUB, c_OP_BEQ, c_OP_BNE, c_OP_BLTZ: bus.ALUOp = 3'b001;
                    c_OP_SLL:                                bus.ALUOp = 3'b010;
                    c_OP_OR, c_OP_ORI:                       bus.ALUOp = 3'b011;
                    c_OP_AND, c_OP_ANDI:                     bus.ALUOp = 3'b100;
                    c_OP_SLT, c_OP_SLTI:                     bus.ALUOp = 3'b110;
                    default:                                 bus.ALUOp = 3'b000;
                endcase
            end
            case (state_q)
                S_IF: bus.IRWre = 1'b1;
                S_ID: begin
                    // Jumps and nops retire here; halt keeps PCWre low forever.
                    if (w_is_jump || !w_is_defined) bus.PCWre = 1'b1;
                    if (w_op == c_OP_JAL)           bus.RegWrite = 1'b1;
                    if (w_op == c_OP_J || w_op == c_OP_JAL) bus.PCSrc = 2'b11;
                    else if (w_op == c_OP_JR)               bus.PCSrc = 2'b10;
                end
                S_EXE_BR: begin
                    bus.PCWre = 1'b1;
                    if ((w_op == c_OP_BEQ  &&  bus.zero) ||
                        (w_op == c_OP_BNE  && !bus.zero) ||
                        (w_op == c_OP_BLTZ &&  bus.sign))
                        bus.PCSrc = 2'b01;
                end
                S_MEM: begin
                    if (w_op == c_OP_LW) bus.mRD = 1'b1;
                    else begin
                        bus.mWR   = 1'b1;
                        bus.PCWre = 1'b1;
                    end
                end
                S_WB_L: begin
                    bus.PCWre     = 1'b1;
                    bus.RegWrite  = 1'b1;
                    bus.MemtoReg  = 1'b1;
                    bus.WrRegDSrc = 1'b1;
                end
                S_WB_R: begin
                    bus.PCWre     = 1'b1;
                    bus.RegWrite  = 1'b1;
                    bus.WrRegDSrc = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_control.sv
// ============================================================================
//  Module      : tb_multi_cycle_control
//  Description : Self-checking bench for multi_cycle_control: per-cycle
//                vector table plus reset and halt sequences.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_cycle_control;

    logic CLK;
    logic Reset;
    int   tests;
    int   fails;

    multi_cycle_control_if bus ();

    multi_cycle_control dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // en = {PCWre, IRWre, RegWrite, MemtoReg, mRD, mWR}
    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       s;
        logic [2:0] st;
        logic [5:0] en;
        logic [1:0] pcsrc;
        logic       chk;
        logic [1:0] regdst;
        logic [2:0] aluop;
        logic       wrs;
    } vec_t;

    vec_t tbl [0:63];
    int   n;

    task automatic add_row(input logic [5:0] op, input logic z, input logic s,
                           input logic [2:0] st, input logic [5:0] en, input logic [1:0] pcsrc,
                           input logic chk, input logic [1:0] regdst, input logic [2:0] aluop,
                           input logic wrs);
        tbl[n].op = op;   tbl[n].z = z;     tbl[n].s = s;
        tbl[n].st = st;   tbl[n].en = en;   tbl[n].pcsrc = pcsrc;
        tbl[n].chk = chk; tbl[n].regdst = regdst; tbl[n].aluop = aluop;
        tbl[n].wrs = wrs;
        n++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] act_en();
        return {bus.PCWre, bus.IRWre, bus.RegWrite, bus.MemtoReg, bus.mRD, bus.mWR};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic rst_pulse();
        Reset = 1'b0;
        #1;
        Reset = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        n     = 0;

        // add: IF, ID, EXE_R, WB_R
        add_row(6'b000000,0,0,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b000000,0,0,3'd1,6'b000000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b000000,0,0,3'd6,6'b000000,2'b00,1,2'b10,3'b000,0);
        add_row(6'b000000,0,0,3'd7,6'b101000,2'b00,1,2'b10,3'b000,1);
        // lw: IF, ID, EXE_MEM, MEM, WB_L
        add_row(6'b110001,0,0,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110001,0,0,3'd1,6'b000000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110001,0,0,3'd2,6'b000000,2'b00,1,2'b01,3'b000,0);
        add_row(6'b110001,0,0,3'd3,6'b000010,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110001,0,0,3'd4,6'b101100,2'b00,1,2'b01,3'b000,1);
        // sw: IF, ID, EXE_MEM, MEM
        add_row(6'b110000,0,0,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110000,0,0,3'd1,6'b000000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110000,0,0,3'd2,6'b000000,2'b00,1,2'b00,3'b000,0);
        add_row(6'b110000,0,0,3'd3,6'b100001,2'b00,0,2'b00,3'b000,0);
        // beq taken / not taken
        add_row(6'b110100,1,0,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110100,1,0,3'd1,6'b000000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110100,1,0,3'd5,6'b100000,2'b01,1,2'b00,3'b001,0);
        add_row(6'b110100,0,0,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110100,0,0,3'd1,6'b000000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110100,0,0,3'd5,6'b100000,2'b00,1,2'b00,3'b001,0);
        // bne with zero=0 is taken
        add_row(6'b110101,0,0,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110101,0,0,3'd1,6'b000000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110101,0,0,3'd5,6'b100000,2'b01,1,2'b00,3'b001,0);
        // bltz: sign=1 taken, sign=0 (zero=1) not taken
        add_row(6'b110110,0,1,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110110,0,1,3'd1,6'b000000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110110,0,1,3'd5,6'b100000,2'b01,1,2'b00,3'b001,0);
        add_row(6'b110110,1,0,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110110,1,0,3'd1,6'b000000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b110110,1,0,3'd5,6'b100000,2'b00,1,2'b00,3'b001,0);
        // jal: link in ID to $31 with PC+4
        add_row(6'b111010,0,0,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b111010,0,0,3'd1,6'b101000,2'b11,1,2'b00,3'b000,0);
        // j, jr, undefined (nop)
        add_row(6'b111000,0,0,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b111000,0,0,3'd1,6'b100000,2'b11,0,2'b00,3'b000,0);
        add_row(6'b111001,0,0,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b111001,0,0,3'd1,6'b100000,2'b10,0,2'b00,3'b000,0);
        add_row(6'b000011,0,0,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b000011,0,0,3'd1,6'b100000,2'b00,0,2'b00,3'b000,0);
        // slti: immediate, signed slt
        add_row(6'b100110,0,0,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b100110,0,0,3'd1,6'b000000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b100110,0,0,3'd6,6'b000000,2'b00,1,2'b01,3'b110,0);
        add_row(6'b100110,0,0,3'd7,6'b101000,2'b00,1,2'b01,3'b110,1);
        // ori
        add_row(6'b010010,0,0,3'd0,6'b010000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b010010,0,0,3'd1,6'b000000,2'b00,0,2'b00,3'b000,0);
        add_row(6'b010010,0,0,3'd6,6'b000000,2'b00,1,2'b01,3'b011,0);
        add_row(6'b010010,0,0,3'd7,6'b101000,2'b00,1,2'b01,3'b011,1);

        // Reset state
        Reset      = 1'b0;
        bus.opcode = 6'b000000;
        bus.zero   = 1'b0;
        bus.sign   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_state", {29'd0, bus.state}, 32'd0);
        check("reset_en", {26'd0, act_en()}, 32'd0);
        Reset = 1'b1;
        #1;
        check("release_irwre", {31'd0, bus.IRWre}, 32'd1);

        // Table: one row per clock cycle
        for (int i = 0; i < n; i++) begin
            bus.opcode = tbl[i].op;
            bus.zero   = tbl[i].z;
            bus.sign   = tbl[i].s;
            @(negedge CLK);
            check($sformatf("row%0d_ctrl", i),
                  {20'd0, bus.state, act_en(), bus.PCSrc, (tbl[i].en[3] ? bus.WrRegDSrc : 1'b0)},
                  {20'd0, tbl[i].st, tbl[i].en, tbl[i].pcsrc, (tbl[i].en[3] ? tbl[i].wrs : 1'b0)});
            if (tbl[i].chk)
                check($sformatf("row%0d_sel", i), {27'd0, bus.RegDst, bus.ALUOp},
                      {27'd0, tbl[i].regdst, tbl[i].aluop});
            step();
        end

        // Reset dropped in WB_R: write enable dies immediately
        bus.opcode = 6'b000000;
        step(); step();
        check("add_exe_r", {29'd0, bus.state}, 32'd6);
        step();
        check("add_wb_r_rw", {31'd0, bus.RegWrite}, 32'd1);
        Reset = 1'b0;
        #1;
        check("rst_wbr_state", {29'd0, bus.state}, 32'd0);
        check("rst_wbr_en", {28'd0, bus.PCWre, bus.RegWrite, bus.mWR, bus.IRWre}, 32'd0);
        step();
        Reset = 1'b1;
        #1;
        check("rst_wbr_release", {28'd0, bus.state, bus.IRWre}, 32'd1);

        // Reset dropped in MEM of sw: store strobe dies immediately
        bus.opcode = 6'b110000;
        step(); step(); step();
        check("sw_mem_mwr", {29'd0, bus.state}, 32'd3);
        Reset = 1'b0;
        #1;
        check("rst_mem_en", {29'd0, bus.PCWre, bus.mWR, bus.state == 3'd0}, 32'd1);
        Reset = 1'b1;
        #1;

        // Selects: ori zero-extends, addiu sign-extends, sll uses shamt
        bus.opcode = 6'b010010;
        step();
        check("ori_ext", {30'd0, bus.ExtSel, bus.ALUSrcB}, 32'b01);
        rst_pulse();
        bus.opcode = 6'b000010;
        step();
        check("addiu_ext", {27'd0, bus.ExtSel, bus.ALUSrcB, bus.RegDst, bus.ALUSrcA}, 32'b11010);
        rst_pulse();
        bus.opcode = 6'b011000;
        step(); step();
        check("sll_exe", {26'd0, bus.ALUSrcA, bus.ALUSrcB, bus.RegDst, bus.ALUOp[1:0]}, 32'b101010);
        rst_pulse();

        // Halt: parks in ID with enables low
        bus.opcode = 6'b111111;
        step();
        for (int k = 0; k < 20; k++) begin
            check($sformatf("halt%0d", k),
                  {26'd0, bus.state, bus.PCWre, bus.RegWrite, bus.IRWre}, {26'd0, 3'd1, 3'b000});
            step();
        end
        rst_pulse();
        check("halt_exit", {28'd0, bus.state, bus.IRWre}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
